// File: rtl/alu_seq_pkg.sv
// Shared ALU instruction codes and sequencer state encoding for alu_sequencer.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    INST_NOP = 4'd0,
    INST_LDA = 4'd1,
    INST_LDB = 4'd2,
    INST_ADD = 4'd3,
    INST_SUB = 4'd4
  } inst_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_EXEC,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Two-port request/response bus between requesters (master) and alu_sequencer (slave).
interface alu_sequencer_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter: on contention the port not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end
endmodule

// File: rtl/alu_sequencer.sv
// Sequences a load-A / load-B / execute program on an external ALU for two requesters.
// Optional subtract support is enabled by defining ALU_SEQ_SUB_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned RET_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  alu_sequencer_if.slave   bus,
  output logic [7:0]       alu_in,
  output logic [3:0]       alu_inst,
  input  logic [7:0]       alu_ret,
  output logic             busy
);

  state_e     state;
  logic [1:0] grant;
  logic       last;
  logic       port_q;
  logic [7:0] b_q;
  logic [1:0] cnt;
  logic [7:0] a_sel;
  logic [7:0] b_sel;

  rr_arb2 u_arb (
    .req   (bus.req_valid),
    .last  (last),
    .grant (grant)
  );

  assign a_sel = grant[1] ? bus.req_a[15:8] : bus.req_a[7:0];
  assign b_sel = grant[1] ? bus.req_b[15:8] : bus.req_b[7:0];

  // Ready is the live grant so a request is accepted on the very edge it wins.
  assign bus.req_ready = (reset_n && state == S_IDLE) ? grant : '0;
  assign busy          = (state != S_IDLE);

`ifdef ALU_SEQ_SUB_EN
  logic op_q;
  logic op_sel;
  assign op_sel = grant[1] ? bus.req_op[1] : bus.req_op[0];
`else
  logic unused_op;
  assign unused_op = ^bus.req_op;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      alu_inst      <= INST_NOP;
      alu_in        <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      last          <= 1'b1;
      port_q        <= 1'b0;
      b_q           <= '0;
      cnt           <= '0;
`ifdef ALU_SEQ_SUB_EN
      op_q          <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            port_q   <= grant[1];
            last     <= grant[1];
            b_q      <= b_sel;
`ifdef ALU_SEQ_SUB_EN
            op_q     <= op_sel;
`endif
            alu_inst <= INST_LDA;
            alu_in   <= a_sel;
            state    <= S_LDA;
          end
        end
        S_LDA: begin
          alu_inst <= INST_LDB;
          alu_in   <= b_q;
          state    <= S_LDB;
        end
        S_LDB: begin
`ifdef ALU_SEQ_SUB_EN
          alu_inst <= op_q ? INST_SUB : INST_ADD;
`else
          alu_inst <= INST_ADD;
`endif
          alu_in   <= '0;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          alu_inst <= INST_NOP;
          cnt      <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 2'(RET_LAT - 1)) begin
            bus.rsp_data  <= alu_ret;
            bus.rsp_valid <= port_q ? 2'b10 : 2'b01;
            state         <= S_RESP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_RESP: begin
          if (|(bus.rsp_valid & bus.rsp_ready)) begin
            bus.rsp_valid <= '0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural one-cycle ALU.
module tb_alu_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] alu_in;
  logic [3:0] alu_inst;
  logic [7:0] alu_ret;
  logic       busy;

  int checks = 0;
  int errors = 0;

  alu_sequencer_if bus ();

  alu_sequencer #(.RET_LAT(1)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .alu_in   (alu_in),
    .alu_inst (alu_inst),
    .alu_ret  (alu_ret),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // ALU: A/B registers and a result register updated by the issued instruction.
  logic [7:0] alu_a = '0;
  logic [7:0] alu_b = '0;
  logic [7:0] alu_r = '0;
  always @(posedge clock) begin
    case (alu_inst)
      4'd1: alu_a <= alu_in;
      4'd2: alu_b <= alu_in;
      4'd3: alu_r <= alu_a + alu_b;
      4'd4: alu_r <= alu_a - alu_b;
      default: ;
    endcase
  end
  assign alu_ret = alu_r;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one request on port p and returns traces once the response shows up.
  task automatic do_op(input int p, input logic [7:0] a, input logic [7:0] b, input logic op,
                       output logic [15:0] inst_tr, output logic [23:0] in_tr,
                       output int lat, output logic [1:0] vld, output logic [7:0] data);
    int n;
    bus.req_valid = '0;
    bus.req_valid[p] = 1'b1;
    bus.req_a[8*p +: 8] = a;
    bus.req_b[8*p +: 8] = b;
    bus.req_op[p] = op;
    #1;
    n = 0;
    while (bus.req_ready[p] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout port=%0d req_ready=%b", p, bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    bus.req_a = 16'hA5A5;
    bus.req_b = 16'h5A5A;
    bus.req_op = 2'b11;
    inst_tr = '0;
    in_tr = '0;
    lat = 0;
    while (bus.rsp_valid === 2'b00 && lat < 20) begin
      if (lat < 4) inst_tr[15 - 4*lat -: 4] = alu_inst;
      if (lat < 3) in_tr[23 - 8*lat -: 8] = alu_in;
      tick();
      lat++;
    end
    if (lat >= 20) begin
      errors++;
      $display("FAIL rsp_timeout port=%0d rsp_valid=%b", p, bus.rsp_valid);
    end
    vld = bus.rsp_valid;
    data = bus.rsp_data;
  endtask

  task automatic finish_rsp(output int cyc);
    bus.rsp_ready = 2'b11;
    cyc = 0;
    while (bus.rsp_valid !== 2'b00 && cyc < 10) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    checks++; if (alu_inst !== 4'd0) begin errors++; $display("FAIL reset_inst got=%h exp=0", alu_inst); end
    checks++; if (alu_in !== 8'd0) begin errors++; $display("FAIL reset_in got=%h exp=0", alu_in); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'd0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=00", bus.rsp_data); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    bus.req_valid = '0;
    tick();
    reset_n = 1'b1;
    #1;
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL first_winner got=%b exp=01", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_basic();
    logic [15:0] it; logic [23:0] ir; int lat; logic [1:0] vld; logic [7:0] d; int cyc;
    bus.rsp_ready = 2'b11;
    do_op(0, 8'h12, 8'h34, 1'b0, it, ir, lat, vld, d);
    checks++; if (it !== 16'h1230) begin errors++; $display("FAIL basic_inst_seq got=%h exp=1230", it); end
    checks++; if (ir !== 24'h123400) begin errors++; $display("FAIL basic_alu_in_seq got=%h exp=123400", ir); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (vld !== 2'b01) begin errors++; $display("FAIL basic_rsp_valid got=%b exp=01", vld); end
    checks++; if (d !== 8'h46) begin errors++; $display("FAIL basic_rsp_data got=%h exp=46", d); end
    finish_rsp(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL basic_handshake_cycles got=%0d exp=1", cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_wrap();
    logic [15:0] it; logic [23:0] ir; int lat; logic [1:0] vld; logic [7:0] d; int cyc;
    do_op(1, 8'hF0, 8'h20, 1'b0, it, ir, lat, vld, d);
    checks++; if (vld !== 2'b10) begin errors++; $display("FAIL wrap_rsp_valid got=%b exp=10", vld); end
    checks++; if (d !== 8'h10) begin errors++; $display("FAIL wrap_rsp_data got=%h exp=10", d); end
    finish_rsp(cyc);
  endtask

  task automatic test_back_to_back();
    logic [1:0] g; logic [1:0] eg; logic [7:0] ed; int n;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.rsp_ready = 2'b11;
    bus.req_a = {8'h02, 8'h01};
    bus.req_b = {8'h20, 8'h10};
    bus.req_op = 2'b00;
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
      ed = (i % 2 == 1) ? 8'h22 : 8'h11;
      n = 0;
      while (bus.req_ready === 2'b00 && n < 20) begin tick(); n++; end
      g = bus.req_ready;
      checks++; if (g !== eg) begin errors++; $display("FAIL b2b_grant op=%0d got=%b exp=%b", i, g, eg); end
      tick();
      n = 0;
      while (bus.rsp_valid === 2'b00 && n < 20) begin tick(); n++; end
      checks++; if (bus.rsp_valid !== eg) begin errors++; $display("FAIL b2b_rsp_valid op=%0d got=%b exp=%b", i, bus.rsp_valid, eg); end
      checks++; if (bus.rsp_data !== ed) begin errors++; $display("FAIL b2b_rsp_data op=%0d got=%h exp=%h", i, bus.rsp_data, ed); end
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_hold();
    logic [15:0] it; logic [23:0] ir; int lat; logic [1:0] vld; logic [7:0] d; int cyc;
    bus.rsp_ready = 2'b00;
    do_op(0, 8'h21, 8'h43, 1'b0, it, ir, lat, vld, d);
    checks++; if (d !== 8'h64) begin errors++; $display("FAIL hold_first_data got=%h exp=64", d); end
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL hold_rsp_valid cyc=%0d got=%b exp=01", i, bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 8'h64) begin errors++; $display("FAIL hold_rsp_data cyc=%0d got=%h exp=64", i, bus.rsp_data); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL hold_req_ready cyc=%0d got=%b exp=00", i, bus.req_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy cyc=%0d got=%b exp=1", i, busy); end
    end
    bus.req_valid = '0;
    finish_rsp(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL hold_release_cycles got=%0d exp=1", cyc); end
  endtask

  task automatic test_reset_exec();
    logic [15:0] it; logic [23:0] ir; int lat; logic [1:0] vld; logic [7:0] d; int n; int cyc;
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    bus.req_a = 16'h0009;
    bus.req_b = 16'h0009;
    #1;
    n = 0;
    while (bus.req_ready !== 2'b01 && n < 20) begin tick(); n++; end
    tick();
    bus.req_valid = '0;
    n = 0;
    while (alu_inst !== 4'd3 && n < 20) begin tick(); n++; end
    checks++; if (alu_inst !== 4'd3) begin errors++; $display("FAIL rexec_reach_exec got=%h exp=3", alu_inst); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (alu_inst !== 4'd0) begin errors++; $display("FAIL rexec_inst got=%h exp=0", alu_inst); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rexec_rsp_valid got=%b exp=00", bus.rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rexec_busy got=%b exp=0", busy); end
    tick();
    reset_n = 1'b1;
    bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL rexec_ready_after_release got=%b exp=10", bus.req_ready); end
    do_op(1, 8'h33, 8'h44, 1'b0, it, ir, lat, vld, d);
    checks++; if (vld !== 2'b10) begin errors++; $display("FAIL rexec_rsp_valid2 got=%b exp=10", vld); end
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL rexec_rsp_data got=%h exp=77", d); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL rexec_latency got=%0d exp=4", lat); end
    finish_rsp(cyc);
  endtask

  task automatic test_sub();
    logic [15:0] it; logic [23:0] ir; int lat; logic [1:0] vld; logic [7:0] d; int cyc;
    logic [15:0] exp_it; logic [7:0] exp_d;
`ifdef ALU_SEQ_SUB_EN
    exp_it = 16'h1240; exp_d = 8'hFE;
`else
    exp_it = 16'h1230; exp_d = 8'h0C;
`endif
    do_op(0, 8'h05, 8'h07, 1'b1, it, ir, lat, vld, d);
    checks++; if (it !== exp_it) begin errors++; $display("FAIL sub_inst_seq got=%h exp=%h", it, exp_it); end
    checks++; if (d !== exp_d) begin errors++; $display("FAIL sub_rsp_data got=%h exp=%h", d, exp_d); end
    finish_rsp(cyc);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_hold();
    test_reset_exec();
    test_sub();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
